// File: rtl/instr_tlb.sv
// Instruction TLB: fully-associative VPN->PPN cache with registered lookup and
// a single-read Wishbone page-table walker that refills entries round-robin.
module instr_tlb #(
    parameter int unsigned ENTRIES = 8,
    parameter logic [31:0] PT_BASE = 32'h0001_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        vpn_to_ppn_req,
    input  logic [19:0] vpn,
    input  logic        freeze_tlb,
    output logic [25:0] tag_out,
    output logic        tag_hit,
    output logic        freeze,
    input  logic        wb_ack_i,
    input  logic        wb_err_i,
    input  logic        wb_rty_i,
    input  logic [31:0] wb_dat_i,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    output logic        wb_we_o,
    output logic [31:0] wb_adr_o,
    output logic [2:0]  wb_bte_o,
    output logic [2:0]  wb_cti_o,
    output logic [3:0]  wb_sel_o,
    output logic [31:0] wb_dat_o
);

    localparam int unsigned PTR_W = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;

    typedef enum logic [1:0] {IDLE, REQ, WAIT_RTY} state_t;

    state_t             state;
    logic [ENTRIES-1:0] ent_valid;
    logic [19:0]        ent_vpn   [ENTRIES];
    logic [21:0]        ent_ppn   [ENTRIES];
    logic [3:0]         ent_flags [ENTRIES];
    logic [PTR_W-1:0]   rr_ptr;
    logic               lkp_valid;
    logic [19:0]        lkp_vpn;
    logic               match;
    logic [25:0]        match_tag;
    logic               fill;
    logic [3:0]         fill_flags;
    logic               unused_pte_bits;

    always_comb begin
        match     = 1'b0;
        match_tag = '0;
        for (int unsigned i = 0; i < ENTRIES; i++) begin
            if (ent_valid[i] && ent_vpn[i] == lkp_vpn) begin
                match     = 1'b1;
                match_tag = {ent_ppn[i], ent_flags[i]};
            end
        end
    end

    assign tag_hit = lkp_valid & match;
    assign tag_out = tag_hit ? match_tag : '0;
    assign freeze  = (state != IDLE) | (lkp_valid & ~match);

    // An error response still installs the entry (flags cleared) so a bad PTE
    // cannot make the walker retry forever.
    assign fill       = (state == REQ) & (wb_ack_i | wb_err_i);
    assign fill_flags = wb_ack_i ? wb_dat_i[3:0] : 4'b0000;

    assign wb_we_o  = 1'b0;
    assign wb_bte_o = '0;
    assign wb_cti_o = 3'b000;
    assign wb_dat_o = '0;

    assign unused_pte_bits = ^wb_dat_i[9:4];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            lkp_valid <= 1'b0;
            lkp_vpn   <= '0;
            rr_ptr    <= '0;
            ent_valid <= '0;
            wb_cyc_o  <= 1'b0;
            wb_stb_o  <= 1'b0;
            wb_adr_o  <= '0;
            wb_sel_o  <= '0;
        end else begin
            if (vpn_to_ppn_req && !freeze) begin
                lkp_vpn   <= vpn;
                lkp_valid <= 1'b1;
            end
            if (fill) begin
                ent_valid[rr_ptr] <= 1'b1;
                rr_ptr <= (rr_ptr == PTR_W'(ENTRIES - 1)) ? '0 : rr_ptr + PTR_W'(1);
            end
            case (state)
                IDLE: begin
                    if (lkp_valid && !match && !freeze_tlb) begin
                        state    <= REQ;
                        wb_cyc_o <= 1'b1;
                        wb_stb_o <= 1'b1;
                        wb_sel_o <= 4'hF;
                        wb_adr_o <= PT_BASE + {10'b0, lkp_vpn, 2'b00};
                    end
                end
                REQ: begin
                    if (wb_ack_i || wb_err_i || wb_rty_i) begin
                        state    <= wb_rty_i && !wb_ack_i && !wb_err_i ? WAIT_RTY : IDLE;
                        wb_cyc_o <= 1'b0;
                        wb_stb_o <= 1'b0;
                        wb_sel_o <= '0;
                    end
                end
                WAIT_RTY: begin
                    state    <= REQ;
                    wb_cyc_o <= 1'b1;
                    wb_stb_o <= 1'b1;
                    wb_sel_o <= 4'hF;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (fill) begin
            ent_vpn[rr_ptr]   <= lkp_vpn;
            ent_ppn[rr_ptr]   <= wb_dat_i[31:10];
            ent_flags[rr_ptr] <= fill_flags;
        end
    end

endmodule

// File: tb/tb_instr_tlb.sv
// Self-checking bench for instr_tlb: a FIFO-of-fills reference model plus a
// Wishbone responder, driven by directed scenarios and random lookups.
module tb_instr_tlb;

    localparam int unsigned ENTRIES = 8;
    localparam logic [31:0] PT_BASE = 32'h0001_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        vpn_to_ppn_req = 1'b0;
    logic [19:0] vpn = '0;
    logic        freeze_tlb = 1'b0;
    logic [25:0] tag_out;
    logic        tag_hit;
    logic        freeze;
    logic        wb_ack_i = 1'b0;
    logic        wb_err_i = 1'b0;
    logic        wb_rty_i = 1'b0;
    logic [31:0] wb_dat_i = '0;
    logic        wb_cyc_o;
    logic        wb_stb_o;
    logic        wb_we_o;
    logic [31:0] wb_adr_o;
    logic [2:0]  wb_bte_o;
    logic [2:0]  wb_cti_o;
    logic [3:0]  wb_sel_o;
    logic [31:0] wb_dat_o;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [19:0] vpn;
        logic [25:0] tag;
    } tlb_ent_t;

    tlb_ent_t model_q[$];

    instr_tlb #(.ENTRIES(ENTRIES), .PT_BASE(PT_BASE)) dut (
        .clk(clk), .rst(rst), .vpn_to_ppn_req(vpn_to_ppn_req), .vpn(vpn),
        .freeze_tlb(freeze_tlb), .tag_out(tag_out), .tag_hit(tag_hit), .freeze(freeze),
        .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i), .wb_rty_i(wb_rty_i), .wb_dat_i(wb_dat_i),
        .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o), .wb_adr_o(wb_adr_o),
        .wb_bte_o(wb_bte_o), .wb_cti_o(wb_cti_o), .wb_sel_o(wb_sel_o), .wb_dat_o(wb_dat_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int model_find(input logic [19:0] v);
        for (int i = 0; i < model_q.size(); i++)
            if (model_q[i].vpn == v) return i;
        return -1;
    endfunction

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("rst_hit", tag_hit, 0);
        check("rst_tag", tag_out, 0);
        check("rst_freeze", freeze, 0);
        check("rst_cyc", wb_cyc_o, 0);
        check("rst_adr", wb_adr_o, 0);
        step();
        rst = 1'b0;
        model_q.delete();
    endtask

    // One lookup of v; on a miss the walk is answered by n_rty retries, wait_st
    // idle cycles, then ack (or err) carrying pte. ftlb_cycles holds freeze_tlb.
    task automatic lookup(input logic [19:0] v, input logic [31:0] pte, input int n_rty,
                          input bit use_err, input int wait_st, input int ftlb_cycles);
        int idx;
        bit exp_hit;
        logic [25:0] exp_tag;
        logic [31:0] exp_adr;
        tlb_ent_t e;
        idx     = model_find(v);
        exp_hit = (idx >= 0);
        exp_tag = exp_hit ? model_q[idx].tag : '0;
        exp_adr = PT_BASE + 32'(v) * 4;

        freeze_tlb     = (ftlb_cycles > 0);
        vpn_to_ppn_req = 1'b1;
        vpn            = v;
        step();
        vpn_to_ppn_req = 1'b0;
        vpn            = 20'($urandom);
        check("lkp_hit", tag_hit, exp_hit);
        check("lkp_tag", tag_out, exp_tag);
        check("lkp_freeze", freeze, !exp_hit);
        check("lkp_cyc", wb_cyc_o, 0);
        if (exp_hit) begin
            freeze_tlb = 1'b0;
            return;
        end

        for (int k = 0; k < ftlb_cycles; k++) begin
            step();
            check("ftlb_cyc", wb_cyc_o, 0);
            check("ftlb_freeze", freeze, 1);
        end
        freeze_tlb = 1'b0;
        step();
        check("walk_start", wb_cyc_o, 1);
        if (!wb_cyc_o) return;
        check("walk_stb", wb_stb_o, 1);
        check("walk_adr", wb_adr_o, exp_adr);
        check("walk_sel", wb_sel_o, 4'hF);
        check("walk_we", wb_we_o, 0);
        check("walk_cti", wb_cti_o, 0);

        for (int r = 0; r < n_rty; r++) begin
            wb_rty_i = 1'b1;
            step();
            wb_rty_i = 1'b0;
            check("rty_stb_low", wb_stb_o, 0);
            check("rty_freeze", freeze, 1);
            step();
            check("rty_stb_high", wb_stb_o, 1);
            check("rty_adr", wb_adr_o, exp_adr);
            if (!wb_stb_o) return;
        end
        for (int w = 0; w < wait_st; w++) begin
            step();
            check("wait_freeze", freeze, 1);
        end

        wb_dat_i = pte;
        if (use_err) wb_err_i = 1'b1;
        else         wb_ack_i = 1'b1;
        step();
        wb_ack_i = 1'b0;
        wb_err_i = 1'b0;
        wb_dat_i = $urandom;
        exp_tag  = {pte[31:10], use_err ? 4'b0000 : pte[3:0]};
        check("fill_hit", tag_hit, 1);
        check("fill_tag", tag_out, exp_tag);
        check("fill_freeze", freeze, 0);
        check("fill_cyc", wb_cyc_o, 0);

        e.vpn = v;
        e.tag = exp_tag;
        model_q.push_back(e);
        if (model_q.size() > ENTRIES) void'(model_q.pop_front());

        step();
        check("idle_cyc", wb_cyc_o, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        logic [19:0] v;
        #1;
        check("por_hit", tag_hit, 0);
        check("por_freeze", freeze, 0);
        do_reset();

        // Scenario 1/2: first miss and fill, then a hit with no bus cycle
        lookup(20'h00012, 32'h1234_540F, 0, 1'b0, 0, 0);
        check("s1_tag_const", tag_out, {22'h048D15, 4'hF});
        lookup(20'h00012, 32'h0, 0, 1'b0, 0, 0);

        // Scenario 3: nine fills evict the oldest entry
        do_reset();
        for (int i = 0; i < 9; i++) lookup(20'(i), $urandom, 0, 1'b0, 0, 0);
        lookup(20'h8, 32'h0, 0, 1'b0, 0, 0);
        check("s3_vpn0_evicted", model_find(20'h0) < 0, 1);
        lookup(20'h0, $urandom, 0, 1'b0, 1, 0);

        // Scenario 4/5/6: retry, error, external freeze
        lookup(20'hABCDE, 32'hDEAD_BC07, 1, 1'b0, 0, 0);
        lookup(20'h55555, 32'hFFFF_FFFF, 0, 1'b1, 0, 0);
        step();
        check("s5_no_rewalk", wb_cyc_o, 0);
        lookup(20'h55555, 32'h0, 0, 1'b0, 0, 0);
        lookup(20'h77777, $urandom, 0, 1'b0, 0, 3);

        // Reset mid-walk aborts without installing
        vpn_to_ppn_req = 1'b1;
        vpn = 20'h0F0F0;
        step();
        vpn_to_ppn_req = 1'b0;
        step();
        check("abort_cyc_before", wb_cyc_o, 1);
        rst = 1'b1;
        #1;
        check("abort_cyc", wb_cyc_o, 0);
        check("abort_stb", wb_stb_o, 0);
        check("abort_freeze", freeze, 0);
        check("abort_hit", tag_hit, 0);
        step();
        rst = 1'b0;
        model_q.delete();
        lookup(20'h0F0F0, $urandom, 0, 1'b0, 0, 0);

        // Random traffic over a small VPN pool for hits, misses and evictions
        for (int n = 0; n < 250; n++) begin
            v = 20'($urandom_range(0, 13));
            lookup(v, $urandom,
                   ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0,
                   ($urandom_range(0, 7) == 0),
                   int'($urandom_range(0, 2)),
                   ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 2)) : 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/instr_tlb.md
Name: instr_tlb

Overview:
- Instruction TLB for the I-cache. Translates a 20-bit virtual page number (VPN) to a 22-bit physical page number (PPN) plus 4 permission flags.
- Lookups are registered, so results appear one cycle after the request, matching the cache tag-RAM read latency. The I-cache compares the PPN against its stored tags.
- On a miss the block asserts freeze, fetches the page-table entry (PTE) with a single Wishbone read, installs it, and releases freeze.

Parameters:
- ENTRIES, 8: number of fully-associative TLB entries, replaced round-robin.
- PT_BASE, 32'h0001_0000: byte base address of a linear one-level page table with one 32-bit PTE per VPN.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- vpn_to_ppn_req  in  1  capture vpn for lookup at this edge
- vpn  in  20  virtual page number, address bits [31:12]
- freeze_tlb  in  1  external stall; blocks the start of a new walk
- tag_out  out  26  {PPN[21:0], X, W, R, V} of the matched entry
- tag_hit  out  1  registered VPN matches an entry
- freeze  out  1  translation pending; upstream must stall
- wb_ack_i / wb_err_i / wb_rty_i  in  1 each  Wishbone cycle terminations
- wb_dat_i  in  32  read data (PTE)
- wb_cyc_o, wb_stb_o  out  1 each  bus cycle and strobe
- wb_we_o  out  1  always 0
- wb_adr_o  out  32  PTE address
- wb_bte_o  out  3  always 0
- wb_cti_o  out  3  always 3'b000, classic cycle
- wb_sel_o  out  4  4'hF during a cycle, else 0
- wb_dat_o  out  32  always 0

Behaviour:
- Reset (async) sets:
  - every entry valid bit to 0;
  - the lookup register to lkp_valid=0, lkp_vpn=0;
  - the round-robin pointer to 0 and the walker state to IDLE;
  - all Wishbone outputs to 0.
  - Outputs after reset: tag_hit=0, tag_out=0, freeze=0.
- Entry fields: valid, vpn[19:0], ppn[21:0], flags[3:0].
- Lookup register update: on a clk edge where vpn_to_ppn_req=1 and freeze=0, lkp_vpn<=vpn and lkp_valid<=1. Otherwise it holds.
- Match (combinational, on lkp_vpn):
  - tag_hit = lkp_valid & (any valid entry with entry.vpn==lkp_vpn).
  - tag_out = {ppn, flags} of the matching entry, or 0 when there is no match.
  - Duplicate entries cannot occur, because a fill happens only on a miss.
- freeze = (state!=IDLE) | (lkp_valid & ~tag_hit). It is combinational and rises in the same cycle as the miss.
- Walker states: IDLE, REQ, WAIT_RTY.
  - IDLE to REQ: when lkp_valid & ~tag_hit & ~freeze_tlb.
  - Entering REQ drives wb_cyc_o=wb_stb_o=1, wb_sel_o=4'hF, and wb_adr_o = PT_BASE + {lkp_vpn,2'b00}. These outputs are registered.
  - REQ, on wb_ack_i: write the entry at the round-robin pointer as {valid=1, vpn=lkp_vpn, ppn=wb_dat_i[31:10], flags=wb_dat_i[3:0]}. Increment the pointer mod ENTRIES. Drop cyc/stb and go to IDLE.
  - REQ, on wb_err_i (priority below ack): install the same entry but with flags=4'b0000 as a fault marker, so the walker cannot loop. Go to IDLE.
  - REQ, on wb_rty_i (priority below err): drop cyc/stb for one cycle in WAIT_RTY, then reissue the same address in REQ.
- A PTE with V=0 is installed as is. tag_hit=1 with tag_out[0]=0 signals a fault to the consumer; no extra handling is done here.
- Fill-to-hit latency: tag_hit rises in the cycle after the ack edge, and freeze falls in that same cycle. Miss penalty = 1 (start) + bus latency + 1.
- freeze_tlb=1 only blocks leaving IDLE. An in-flight bus cycle always completes.
- A vpn_to_ppn_req while freeze=1 is ignored. The requester must hold its request until freeze=0.
- Reset during a walk aborts it immediately: cyc/stb go to 0 and nothing is installed.
- Round-robin wraps from ENTRIES-1 to 0, overwriting the oldest fill regardless of use.

Test Plan:
1. Reset, then req with vpn=20'h00012 → next cycle tag_hit=0, freeze=1. One cycle later cyc=stb=1 and wb_adr_o=32'h0001_0048. Ack with wb_dat_i=32'h1234_540F → the following cycle tag_hit=1, tag_out={22'h048D15,4'hF}, freeze=0.
2. Repeat req vpn=20'h00012 → tag_hit=1 one cycle after req, with no bus cycle and freeze staying 0.
3. Fill 9 distinct VPNs 0..8 with ENTRIES=8 → entry 0 (VPN 0) is evicted. A lookup of VPN 0 walks again; a lookup of VPN 8 hits.
4. Miss answered with wb_rty_i for one cycle → stb=0 for one cycle, then stb=1 at the same address. A later ack installs the entry as in scenario 1.
5. Miss answered with wb_err_i → entry installed, tag_hit=1, tag_out[3:0]=0, freeze=0, and no further bus cycle.
6. Miss while freeze_tlb=1 → freeze=1 and cyc stays 0. Release freeze_tlb → walk starts next cycle. Asserting rst mid-walk → cyc=0, freeze=0, tag_hit=0 immediately.
